div_iter_unit: RTL and testbench

- Multi-cycle iterative radix-2 restoring divider serving DIV/DIVU in the EXE stage.
- Source of the `DIV_Busy` flag that the hazard/bypass logic combines with its `DIV` decode to stall ID.
- Results go to the HI/LO write path: quotient to LO, remainder to HI.
- The protocol is issue/busy/done: the pipeline issues one start pulse, then this block holds busy until the result is ready.

---
 rtl/div_iter_unit_if.sv | 44 ++++
 rtl/div_iter_unit.sv | 177 +++++++++++++++++
 tb/tb_div_iter_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_unit_if.sv
// ----------------------------------------------------------------------------
// div_iter_unit_if
//   Issue/busy/done bundle between the EXE stage and the iterative divider.
//
//   Handshake: the master raises div_start for exactly one cycle with
//   div_signed/dividend/divisor stable in that cycle; the slave answers with
//   DIV_Busy while iterating and a one-cycle div_done pulse when
//   quotient/remainder hold the new result. div_cancel aborts any operation
//   in flight and beats a coincident div_start.
//
//   Signals:
//     div_start  (m->s) one-cycle issue pulse
//     div_signed (m->s) 1 = DIV, 0 = DIVU
//     div_cancel (m->s) pipeline flush
//     dividend   (m->s) rs operand
//     divisor    (m->s) rt operand
//     DIV_Busy   (s->m) iteration in progress
//     div_done   (s->m) result valid pulse
//     quotient   (s->m) registered quotient (LO)
//     remainder  (s->m) registered remainder (HI)
// ----------------------------------------------------------------------------
interface div_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic             div_signed;
    logic             div_cancel;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             DIV_Busy;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output div_start, div_signed, div_cancel, dividend, divisor,
        input  DIV_Busy, div_done, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, div_cancel, dividend, divisor,
        output DIV_Busy, div_done, quotient, remainder
    );
endinterface

// File: rtl/div_iter_unit.sv
// ----------------------------------------------------------------------------
// div_iter_unit
//   Multi-cycle radix-2 restoring divider for DIV/DIVU. One quotient bit per
//   cycle, MSB first; WIDTH iterations after the issue edge, result registered
//   on entry to DONE (quotient -> LO, remainder -> HI).
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst      in   synchronous active-high reset
//     bus      slave modport of div_iter_unit_if (issue/busy/done bundle)
//     state_o  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE) for debug
//
//   Optional feature macro: DIV_ZERO_FAST_EN
//     defined   - a start with divisor == 0 goes straight to DONE, div_done
//                 pulses one cycle after the issue edge, DIV_Busy stays low.
//     undefined - divide-by-zero runs the normal WIDTH+1 cycle path.
// ----------------------------------------------------------------------------
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    div_iter_unit_if.slave       bus,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   prem_q;      // partial remainder
    logic [WIDTH-1:0] dvd_q;       // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dsr_q;       // divisor magnitude
    logic [WIDTH-1:0] qacc_q;      // quotient bits collected so far
    logic [WIDTH-1:0] dvd_raw_q;   // raw dividend, returned as remainder on /0
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;

    // Operand magnitudes and sign fix-up flags captured at issue.
    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic             fast_zero_d;

    // One iteration step.
    logic [WIDTH+1:0] shift_d;
    logic [WIDTH+1:0] trial_d;
    logic             qbit_d;
    logic [WIDTH:0]   prem_d;
    logic [WIDTH-1:0] qacc_d;
    logic [WIDTH-1:0] quo_fin_d;
    logic [WIDTH-1:0] rem_fin_d;
    logic             last_iter_d;
    logic             start_ok_d;

    always_comb begin
        a_neg_d     = bus.div_signed & bus.dividend[WIDTH-1];
        b_neg_d     = bus.div_signed & bus.divisor[WIDTH-1];
        a_mag_d     = a_neg_d ? (~bus.dividend + 1'b1) : bus.dividend;
        b_mag_d     = b_neg_d ? (~bus.divisor + 1'b1) : bus.divisor;
        start_ok_d  = bus.div_start & ~bus.div_cancel;
`ifdef DIV_ZERO_FAST_EN
        fast_zero_d = (bus.divisor == '0);
`else
        fast_zero_d = 1'b0;
`endif

        // The extra top bit of shift/trial acts as the borrow: a set bit
        // after the subtraction means the trial went negative.
        shift_d     = {prem_q, dvd_q[WIDTH-1]};
        trial_d     = shift_d - {2'b00, dsr_q};
        qbit_d      = ~trial_d[WIDTH+1];
        prem_d      = qbit_d ? trial_d[WIDTH:0] : shift_d[WIDTH:0];
        qacc_d      = {qacc_q[WIDTH-2:0], qbit_d};
        last_iter_d = (cnt_q == CNT_W'(WIDTH - 1));

        // Final results folded into the DONE-entry write; /0 bypasses the
        // sign fix-up and reports the raw dividend.
        if (dz_q) begin
            quo_fin_d = '1;
            rem_fin_d = dvd_raw_q;
        end else begin
            quo_fin_d = neg_quo_q ? (~qacc_d + 1'b1) : qacc_d;
            rem_fin_d = neg_rem_q ? (~prem_d[WIDTH-1:0] + 1'b1) : prem_d[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            qacc_q    <= '0;
            dvd_raw_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok_d && fast_zero_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= '1;
                        rem_q   <= bus.dividend;
                    end else if (start_ok_d) begin
                        state_q   <= S_BUSY;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        prem_q    <= '0;
                        qacc_q    <= '0;
                        dvd_q     <= a_mag_d;
                        dsr_q     <= b_mag_d;
                        dvd_raw_q <= bus.dividend;
                        neg_quo_q <= a_neg_d ^ b_neg_d;
                        neg_rem_q <= a_neg_d;
                        dz_q      <= (bus.divisor == '0);
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // div_start is deliberately not looked at here.
                    if (bus.div_cancel) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        prem_q <= prem_d;
                        qacc_q <= qacc_d;
                        dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                        cnt_q  <= cnt_q + 1'b1;
                        if (last_iter_d) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            quo_q   <= quo_fin_d;
                            rem_q   <= rem_fin_d;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DIV_Busy  = busy_q;
    assign bus.div_done  = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// ----------------------------------------------------------------------------
// tb_div_iter_unit
//   Directed vectors for div_iter_unit. A driver pushes the expected
//   {quotient, remainder} and the expected done cycle into queues; a monitor
//   pops and compares whenever div_done is seen.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_iter_unit;
    localparam int WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    div_iter_unit_if #(.WIDTH(WIDTH)) bus ();
    logic [1:0] state_dbg;

    div_iter_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [2*WIDTH-1:0] exp_q[$];
    int                 exp_cyc_q[$];
    int                 n_vec  = 0;
    int                 n_fail = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every div_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [2*WIDTH-1:0] e;
        int                 c;
        if (!rst && bus.div_done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got div_done=1 expected 0 q=%h r=%h (cycle %0d)",
                         bus.quotient, bus.remainder, cyc);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("quotient",     bus.quotient,  e[2*WIDTH-1:WIDTH]);
                check("remainder",    bus.remainder, e[WIDTH-1:0]);
                check("done_cycle",   WIDTH'(cyc),   WIDTH'(c));
                check("busy_at_done", WIDTH'(bus.DIV_Busy), '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic sgn, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eq,
                         input logic [WIDTH-1:0] er, input bit expect_res);
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        if (expect_res) begin
            exp_q.push_back({eq, er});
            exp_cyc_q.push_back((FAST && b == '0) ? cyc + 1 : cyc + WIDTH + 1);
        end
        @(negedge clk);
        bus.div_start  = 1'b0;
    endtask

    // Bounded wait for div_done; counts DIV_Busy cycles seen on the way.
    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.div_done) begin
                seen = 1'b1;
                break;
            end
            if (bus.DIV_Busy) busy_cycles++;
            @(negedge clk);
        end
        if (!seen) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got no div_done expected one within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic run_vec(input logic sgn, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eq,
                           input logic [WIDTH-1:0] er);
        int bc;
        bit seen;
        issue(sgn, a, b, eq, er, 1'b1);
        wait_done(bc, seen);
        check("busy_cycles", WIDTH'(bc), (FAST && b == '0) ? '0 : WIDTH'(WIDTH));
        @(negedge clk);
        check("done_one_cycle", WIDTH'(bus.div_done), '0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic             sgn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
    } vec_t;

    vec_t vecs[12] = '{
        '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2},
        '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF},
        '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1},
        '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0},
        '{1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678},
        '{1'b1, 32'hFFFFFF9C,  32'd0,         32'hFFFFFFFF,  32'hFFFFFF9C},
        '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0},
        '{1'b0, 32'd5,         32'd7,         32'd0,         32'd5},
        '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE},
        '{1'b0, 32'hFFFFFFFF,  32'h10,        32'h0FFFFFFF,  32'hF},
        '{1'b1, 32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF},
        '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000}
    };

    initial begin
        int bc;
        bit seen;
        int done_seen;

        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_cancel = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;

        wait_cycles(4);
        rst = 1'b0;
        check("rst_busy",  WIDTH'(bus.DIV_Busy), '0);
        check("rst_done",  WIDTH'(bus.div_done), '0);
        check("rst_quo",   bus.quotient,  '0);
        check("rst_rem",   bus.remainder, '0);
        check("rst_state", WIDTH'(state_dbg), '0);

        // Main function and boundary vectors.
        foreach (vecs[i]) run_vec(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

        // Cancel mid-division: prior result (100/7 -> 14 r 2) must survive.
        run_vec(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        issue(1'b0, 32'd50, 32'd5, '0, '0, 1'b0);   // start at T, now at T+1
        wait_cycles(9);                             // now at T+10
        bus.div_cancel = 1'b1;
        @(negedge clk);
        bus.div_cancel = 1'b0;
        check("cancel_busy",  WIDTH'(bus.DIV_Busy), '0);
        check("cancel_state", WIDTH'(state_dbg), '0);
        check("cancel_quo",   bus.quotient,  32'd14);
        check("cancel_rem",   bus.remainder, 32'd2);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done) done_seen++;
            @(negedge clk);
        end
        check("cancel_no_done", WIDTH'(done_seen), '0);

        // Cancel together with start: start is discarded.
        bus.div_cancel = 1'b1;
        issue(1'b0, 32'd100, 32'd0, '0, '0, 1'b0);
        bus.div_cancel = 1'b0;
        check("cancel_start_busy",  WIDTH'(bus.DIV_Busy), '0);
        check("cancel_start_done",  WIDTH'(bus.div_done), '0);
        check("cancel_start_state", WIDTH'(state_dbg), '0);

        // Reset mid-division, then a normal operation.
        issue(1'b0, 32'd1000, 32'd10, '0, '0, 1'b0); // start at T, now at T+1
        wait_cycles(19);                             // now at T+20
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", WIDTH'(bus.DIV_Busy), '0);
        check("midrst_done", WIDTH'(bus.div_done), '0);
        check("midrst_quo",  bus.quotient,  '0);
        check("midrst_rem",  bus.remainder, '0);
        run_vec(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);

        // Back-to-back: second start issued in the div_done cycle, plus a
        // stray start during BUSY that must be ignored.
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        wait_done(bc, seen);
        issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b1);
        check("b2b_busy", WIDTH'(bus.DIV_Busy), 32'd1);
        wait_cycles(5);
        issue(1'b1, 32'd9999, 32'd1, '0, '0, 1'b0);
        check("stray_start_busy", WIDTH'(bus.DIV_Busy), 32'd1);
        wait_done(bc, seen);
        wait_cycles(3);

        check("queue_drained", WIDTH'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish by 200000ns");
        $fatal(1);
    end

endmodule
